// File: rtl/tile_map_engine.sv
// tile_map_engine
//
// Tile map for an arena-style game. It stores COLS*ROWS tile codes of TILE_W bits each
// (0 empty, 1 soft block, 2 hard wall, 3 power-up). The map has one write port and one
// shared read port. The read port has two users:
//   * the display path, which looks up the tile under the current pixel;
//   * a collision scanner, which runs during blanking. For each player channel it probes
//     one point just beyond the sprite edge in its direction of travel.
//
// Optional feature: define TILE_MAP_CLEAR_EN to build a clear sequencer. A clear_req pulse
// then wipes the whole map to 0, one address per cycle. Without the macro, clear_req is
// ignored and busy is tied low.
//
// Ports
//   clk, reset             sole clock, synchronous active-high reset
//   display_on, arena_on   active video / pixel inside the arena
//   x_a, y_a               arena-relative pixel coordinate (16x16 tiles)
//   q_valid[N_CH]          per-channel query enable, sampled when a scan starts
//   q_x, q_y               10 bits per channel, sprite upper-left screen coordinate
//   q_dir                  2 bits per channel: 0 up, 1 right, 2 down, 3 left
//   blocked[N_CH]          per-channel result; holds its value until that channel is rescanned
//   q_done                 one-cycle pulse once every channel of a scan has updated
//   wr_req, wr_col, wr_row, wr_data   tile write request
//   wr_ack / wr_err        one-cycle response the cycle after wr_req (stored / out of range)
//   tile_code, tile_on     registered tile under the pixel presented one cycle earlier
//   clear_req, busy        clear sequencer control/status (see TILE_MAP_CLEAR_EN)
//   dbg_state              scan FSM state (0 idle, 1 scan, 2 done)
//
// Write handshake: wr_req is a single-cycle request. There is no ready signal; every request
// is consumed in the cycle it is presented, except while a clear is running. Each consumed
// request produces exactly one of wr_ack / wr_err in the following cycle. A request made
// while busy is dropped silently.

module tile_map_engine #(
    parameter int COLS   = 33,
    parameter int ROWS   = 26,
    parameter int TILE_W = 2,
    parameter int N_CH   = 2,
    parameter int X_OFF  = 48,
    parameter int Y_OFF  = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                display_on,
    input  logic                arena_on,
    input  logic [9:0]          x_a,
    input  logic [9:0]          y_a,
    input  logic [N_CH-1:0]     q_valid,
    input  logic [10*N_CH-1:0]  q_x,
    input  logic [10*N_CH-1:0]  q_y,
    input  logic [2*N_CH-1:0]   q_dir,
    output logic [N_CH-1:0]     blocked,
    output logic                q_done,
    input  logic                wr_req,
    input  logic [5:0]          wr_col,
    input  logic [4:0]          wr_row,
    input  logic [TILE_W-1:0]   wr_data,
    output logic                wr_ack,
    output logic                wr_err,
    output logic [TILE_W-1:0]   tile_code,
    output logic                tile_on,
    input  logic                clear_req,
    output logic                busy,
    output logic [1:0]          dbg_state
);

    localparam int DEPTH  = COLS * ROWS;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic [6:0]        COLS_L  = 7'(COLS);
    localparam logic [6:0]        ROWS_L  = 7'(ROWS);
    localparam logic [ADDR_W-1:0] COLS_A  = ADDR_W'(COLS);
    localparam logic [9:0]        X_OFF_L = 10'(X_OFF);
    localparam logic [9:0]        Y_OFF_L = 10'(Y_OFF);
    localparam logic [CH_W-1:0]   LAST_CH = CH_W'(N_CH - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // ------------------------------------------------------------------
    // Map storage: combinational read and a registered consumer. A write
    // and a read of the same address in one cycle therefore see the old data.
    // ------------------------------------------------------------------
    logic [TILE_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] rd_addr;
    logic [TILE_W-1:0] rd_word;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [TILE_W-1:0] mem_wd;

    assign rd_word = mem[rd_addr];

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    // ------------------------------------------------------------------
    // Display lookup
    // ------------------------------------------------------------------
    logic [5:0]        d_col;
    logic [5:0]        d_row;
    logic              d_in_range;
    logic              disp_en;
    logic [ADDR_W-1:0] d_addr;

    assign d_col      = 6'(x_a >> 4);
    assign d_row      = 6'(y_a >> 4);
    assign d_in_range = ({1'b0, d_col} < COLS_L) && ({1'b0, d_row} < ROWS_L);
    assign disp_en    = display_on && arena_on;
    assign d_addr     = ADDR_W'(d_row) * COLS_A + ADDR_W'(d_col);

    // ------------------------------------------------------------------
    // Probe points for all channels. Arithmetic is 10-bit modulo, so a
    // probe left of or above the arena wraps to a large column or row and
    // falls out of range.
    // ------------------------------------------------------------------
    logic [9:0]        px;
    logic [9:0]        py;
    logic [5:0]        pcol;
    logic [5:0]        prow;
    logic [ADDR_W-1:0] p_addr [N_CH];
    logic [N_CH-1:0]   p_oob;

    always_comb begin
        px    = '0;
        py    = '0;
        pcol  = '0;
        prow  = '0;
        p_oob = '0;
        for (int i = 0; i < N_CH; i++) begin
            p_addr[i] = '0;
        end
        for (int i = 0; i < N_CH; i++) begin
            case (q_dir[i*2 +: 2])
                2'd0: begin px = q_x[i*10 +: 10] + 10'd7;  py = q_y[i*10 +: 10] + 10'd8;  end
                2'd1: begin px = q_x[i*10 +: 10] + 10'd16; py = q_y[i*10 +: 10] + 10'd17; end
                2'd2: begin px = q_x[i*10 +: 10] + 10'd7;  py = q_y[i*10 +: 10] + 10'd25; end
                default: begin px = q_x[i*10 +: 10] - 10'd1; py = q_y[i*10 +: 10] + 10'd17; end
            endcase
            px        = px - X_OFF_L;
            py        = py - Y_OFF_L;
            pcol      = 6'(px >> 4);
            prow      = 6'(py >> 4);
            p_oob[i]  = ({1'b0, pcol} >= COLS_L) || ({1'b0, prow} >= ROWS_L);
            p_addr[i] = ADDR_W'(prow) * COLS_A + ADDR_W'(pcol);
        end
    end

    // ------------------------------------------------------------------
    // Scan FSM
    // ------------------------------------------------------------------
    logic [1:0]        state;
    logic [CH_W-1:0]   ch_idx;
    logic [N_CH-1:0]   valid_s;
    logic              disp_prev;
    logic              scan_active;
    logic              s_valid;
    logic              s_oob;
    logic              scan_rd;
    logic              code_blocks;

    // The scanner only reads while display_on is low, so it never contends
    // with the display path for the shared read port.
    assign scan_active = (state == ST_SCAN) && !display_on;
    assign s_valid     = valid_s[ch_idx];
    assign s_oob       = p_oob[ch_idx];
    assign scan_rd     = scan_active && s_valid && !s_oob;
    assign code_blocks = (rd_word == TILE_W'(1)) || (rd_word == TILE_W'(2));

    always_comb begin
        rd_addr = '0;
        if (scan_rd) begin
            rd_addr = p_addr[ch_idx];
        end else if (disp_en && d_in_range) begin
            rd_addr = d_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            ch_idx    <= '0;
            valid_s   <= '0;
            blocked   <= '0;
            disp_prev <= 1'b0;
        end else begin
            disp_prev <= display_on;
            case (state)
                ST_IDLE: begin
                    if (disp_prev && !display_on) begin
                        state   <= ST_SCAN;
                        ch_idx  <= '0;
                        valid_s <= q_valid;
                    end
                end
                ST_SCAN: begin
                    // Video restarting mid-scan abandons the remaining channels.
                    if (display_on) begin
                        state <= ST_IDLE;
                    end else begin
                        if (s_valid) begin
                            blocked[ch_idx] <= s_oob || code_blocks;
                        end
                        if (ch_idx == LAST_CH) begin
                            state <= ST_DONE;
                        end else begin
                            ch_idx <= ch_idx + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign q_done    = (state == ST_DONE);
    assign dbg_state = state;

    // ------------------------------------------------------------------
    // Display output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            tile_code <= '0;
            tile_on   <= 1'b0;
        end else if (disp_en && d_in_range) begin
            tile_code <= rd_word;
            tile_on   <= (rd_word != '0);
        end else begin
            tile_code <= '0;
            tile_on   <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Write port and optional clear sequencer
    // ------------------------------------------------------------------
    logic              w_in_range;
    logic [ADDR_W-1:0] w_addr;
    logic              wr_accept;

    assign w_in_range = ({1'b0, wr_col} < COLS_L) && ({2'b00, wr_row} < ROWS_L);
    assign w_addr     = ADDR_W'(wr_row) * COLS_A + ADDR_W'(wr_col);

`ifdef TILE_MAP_CLEAR_EN
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic              clr_busy;
    logic [ADDR_W-1:0] clr_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            clr_busy <= 1'b0;
            clr_addr <= '0;
        end else if (clr_busy) begin
            if (clr_addr == LAST_ADDR) begin
                clr_busy <= 1'b0;
            end
            clr_addr <= clr_addr + 1'b1;
        end else if (clear_req) begin
            clr_busy <= 1'b1;
            clr_addr <= '0;
        end
    end

    // While clearing, the sequencer owns the write port and user writes are dropped.
    assign busy      = clr_busy;
    assign wr_accept = wr_req && !clr_busy;
    assign mem_we    = clr_busy || (wr_accept && w_in_range);
    assign mem_wa    = clr_busy ? clr_addr : w_addr;
    assign mem_wd    = clr_busy ? '0 : wr_data;
`else
    logic clear_req_unused;

    assign clear_req_unused = clear_req;
    assign busy             = 1'b0;
    assign wr_accept        = wr_req;
    assign mem_we           = wr_accept && w_in_range;
    assign mem_wa           = w_addr;
    assign mem_wd           = wr_data;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ack <= 1'b0;
            wr_err <= 1'b0;
        end else begin
            wr_ack <= wr_accept && w_in_range;
            wr_err <= wr_accept && !w_in_range;
        end
    end

endmodule

// File: tb/tb_tile_map_engine.sv
// Directed testbench for tile_map_engine with default parameters
// (33x26 map, 2 channels, X_OFF 48, Y_OFF 32).
// Inputs change 1 time unit after the rising edge, and outputs are sampled at the same point.

module tb_tile_map_engine;

    logic        clk;
    logic        reset;
    logic        display_on;
    logic        arena_on;
    logic [9:0]  x_a;
    logic [9:0]  y_a;
    logic [1:0]  q_valid;
    logic [19:0] q_x;
    logic [19:0] q_y;
    logic [3:0]  q_dir;
    logic [1:0]  blocked;
    logic        q_done;
    logic        wr_req;
    logic [5:0]  wr_col;
    logic [4:0]  wr_row;
    logic [1:0]  wr_data;
    logic        wr_ack;
    logic        wr_err;
    logic [1:0]  tile_code;
    logic        tile_on;
    logic        clear_req;
    logic        busy;
    logic [1:0]  dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    tile_map_engine dut (
        .clk        (clk),
        .reset      (reset),
        .display_on (display_on),
        .arena_on   (arena_on),
        .x_a        (x_a),
        .y_a        (y_a),
        .q_valid    (q_valid),
        .q_x        (q_x),
        .q_y        (q_y),
        .q_dir      (q_dir),
        .blocked    (blocked),
        .q_done     (q_done),
        .wr_req     (wr_req),
        .wr_col     (wr_col),
        .wr_row     (wr_row),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .wr_err     (wr_err),
        .tile_code  (tile_code),
        .tile_on    (tile_on),
        .clear_req  (clear_req),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_write(input logic [5:0] c, input logic [4:0] r, input logic [1:0] d);
        wr_req  = 1'b1;
        wr_col  = c;
        wr_row  = r;
        wr_data = d;
    endtask

    initial begin
        int n_busy;
        int ack_seen;

        reset = 1'b1; display_on = 1'b0; arena_on = 1'b0; x_a = '0; y_a = '0;
        q_valid = '0; q_x = '0; q_y = '0; q_dir = '0;
        wr_req = 1'b0; wr_col = '0; wr_row = '0; wr_data = '0; clear_req = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_blocked", blocked, 0);
        chk("rst_q_done", q_done, 0);
        chk("rst_wr_ack", wr_ack, 0);
        chk("rst_wr_err", wr_err, 0);
        chk("rst_tile_code", tile_code, 0);
        chk("rst_tile_on", tile_on, 0);
        chk("rst_busy", busy, 0);
        chk("rst_state", dbg_state, 0);
        reset = 1'b0;
        tick();

        // Write (3,2)=2, then display it at pixel (56,40)
        start_write(6'd3, 5'd2, 2'd2);
        tick();
        chk("wr_ack_ok", wr_ack, 1);
        chk("wr_err_ok", wr_err, 0);
        wr_req = 1'b0;
        display_on = 1'b1; arena_on = 1'b1; x_a = 10'd56; y_a = 10'd40;
        tick();
        chk("disp_code_32", tile_code, 2);
        chk("disp_on_32", tile_on, 1);

        // Write (7,1)=1. Its address 40 is also what a naive col-40/row-0 write would hit.
        start_write(6'd7, 5'd1, 2'd1);
        tick();
        chk("wr_ack_71", wr_ack, 1);
        start_write(6'd40, 5'd0, 2'd3);
        tick();
        chk("wr_err_col40", wr_err, 1);
        chk("wr_ack_col40", wr_ack, 0);
        start_write(6'd0, 5'd26, 2'd3);
        tick();
        chk("wr_err_row26", wr_err, 1);
        chk("wr_ack_row26", wr_ack, 0);
        wr_req = 1'b0;
        x_a = 10'd112; y_a = 10'd16;
        tick();
        chk("map_unchanged_71", tile_code, 1);

        // Same-cycle write and read of (3,2): the read returns old data
        x_a = 10'd56; y_a = 10'd40;
        start_write(6'd3, 5'd2, 2'd3);
        tick();
        chk("rw_same_old", tile_code, 2);
        chk("rw_same_ack", wr_ack, 1);
        wr_req = 1'b0;
        tick();
        chk("rw_same_new", tile_code, 3);

        // Empty tile (4,2)=0 gives tile_on low
        start_write(6'd4, 5'd2, 2'd0);
        tick();
        wr_req = 1'b0;
        x_a = 10'd64;
        tick();
        chk("empty_code", tile_code, 0);
        chk("empty_on", tile_on, 0);

        // Outside the arena: tile_code is forced to 0
        x_a = 10'd56; arena_on = 1'b0;
        tick();
        chk("no_arena_code", tile_code, 0);
        chk("no_arena_on", tile_on, 0);
        arena_on = 1'b1;
        tick();
        chk("arena_back_code", tile_code, 3);
        chk("arena_back_on", tile_on, 1);

        // Scan 1: tile (1,1)=1; ch0 probes down into (1,1); ch1 is disabled
        start_write(6'd1, 5'd1, 2'd1);
        tick();
        wr_req = 1'b0;
        q_valid = 2'b01;
        q_x = {10'd0, 10'd64}; q_y = {10'd0, 10'd23}; q_dir = {2'd0, 2'd2};
        display_on = 1'b0;
        tick();
        chk("s1_state_scan", dbg_state, 1);
        chk("s1_blk_e0", blocked, 2'b00);
        chk("s1_done_e0", q_done, 0);
        tick();
        chk("s1_blk_e1", blocked, 2'b01);
        chk("s1_done_e1", q_done, 0);
        tick();
        chk("s1_done_e2", q_done, 1);
        chk("s1_blk_e2", blocked, 2'b01);
        tick();
        chk("s1_done_e3", q_done, 0);
        chk("s1_state_idle", dbg_state, 0);
        display_on = 1'b1;
        tick();

        // Scan 2: (1,1)=3 power-up is not blocking; ch1 probes left past column 0 and wraps
        start_write(6'd1, 5'd1, 2'd3);
        tick();
        wr_req = 1'b0;
        q_valid = 2'b11;
        q_x = {10'd40, 10'd64}; q_y = {10'd23, 10'd23}; q_dir = {2'd3, 2'd2};
        display_on = 1'b0;
        tick();
        tick();
        chk("s2_blk_e1", blocked, 2'b00);
        tick();
        chk("s2_blk_e2", blocked, 2'b10);
        chk("s2_done_e2", q_done, 1);
        tick();
        display_on = 1'b1;
        tick();

        // Scan 3: display_on returns after one scan cycle, so ch1 keeps its old value
        q_x = {10'd64, 10'd40}; q_y = {10'd23, 10'd23}; q_dir = {2'd2, 2'd3};
        display_on = 1'b0;
        tick();
        chk("s3_state_scan", dbg_state, 1);
        tick();
        chk("s3_blk_e1", blocked, 2'b11);
        display_on = 1'b1;
        tick();
        chk("s3_abort_idle", dbg_state, 0);
        chk("s3_abort_blk", blocked, 2'b11);
        for (int i = 0; i < 4; i++) begin
            chk("s3_no_done", q_done, 0);
            tick();
        end

        // Scan 4: right probe into hard wall (2,1), up probe into power-up (1,1)
        start_write(6'd2, 5'd1, 2'd2);
        tick();
        wr_req = 1'b0;
        q_valid = 2'b11;
        q_x = {10'd57, 10'd64}; q_y = {10'd40, 10'd31}; q_dir = {2'd0, 2'd1};
        display_on = 1'b0;
        tick();
        tick();
        chk("s4_done_e1", q_done, 0);
        tick();
        chk("s4_blk", blocked, 2'b01);
        chk("s4_done_e2", q_done, 1);
        tick();
        display_on = 1'b1;
        tick();

        // Scan 5: ch0 disabled holds 1; ch1 probe row is past the bottom; a write lands mid-scan
        q_valid = 2'b10;
        q_x = {10'd64, 10'd57}; q_y = {10'd500, 10'd40}; q_dir = {2'd2, 2'd0};
        display_on = 1'b0;
        start_write(6'd5, 5'd5, 2'd2);
        tick();
        chk("s5_wr_ack", wr_ack, 1);
        wr_req = 1'b0;
        tick();
        tick();
        chk("s5_blk", blocked, 2'b11);
        chk("s5_done", q_done, 1);
        tick();
        display_on = 1'b1; x_a = 10'd80; y_a = 10'd80;
        tick();
        chk("s5_wr_visible", tile_code, 2);

        // Reset during a scan abandons it without q_done; map contents survive
        q_valid = 2'b11;
        display_on = 1'b0;
        tick();
        chk("rs_state_scan", dbg_state, 1);
        reset = 1'b1;
        tick();
        chk("rs_state_idle", dbg_state, 0);
        chk("rs_blocked", blocked, 2'b00);
        chk("rs_q_done", q_done, 0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rs_no_done", q_done, 0);
        end
        display_on = 1'b1;
        tick();
        chk("rs_map_kept", tile_code, 2);

`ifdef TILE_MAP_CLEAR_EN
        // Clear: busy for one cycle per tile; user writes are dropped meanwhile
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        start_write(6'd3, 5'd2, 2'd1);
        n_busy = 0;
        ack_seen = 0;
        while (busy === 1'b1 && n_busy < 2000) begin
            n_busy++;
            if (wr_ack === 1'b1 || wr_err === 1'b1) ack_seen = 1;
            tick();
        end
        wr_req = 1'b0;
        chk("clr_busy_cycles", n_busy, 858);
        chk("clr_no_ack", ack_seen, 0);
        x_a = 10'd56; y_a = 10'd40;
        tick();
        chk("clr_tile_32", tile_code, 0);
        x_a = 10'd80; y_a = 10'd80;
        tick();
        chk("clr_tile_55", tile_code, 0);
        chk("clr_tile_55_on", tile_on, 0);
`else
        // Without the clear feature, clear_req has no effect
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        n_busy = 0;
        ack_seen = 0;
        chk("noclr_busy", busy, 0);
        start_write(6'd3, 5'd2, 2'd1);
        tick();
        wr_req = 1'b0;
        chk("noclr_wr_ack", wr_ack, 1);
        chk("noclr_busy_after", busy, n_busy + ack_seen);
        tick();
        chk("noclr_map_kept", tile_code, 2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tile_map_engine.md
TILE_MAP_ENGINE -- requirements
Module: tile_map_engine

Interface
REQ-001 Parameter COLS, default 33, tile columns in arena map.
REQ-002 Parameter ROWS, default 26, tile rows in arena map.
REQ-003 Parameter TILE_W, default 2, bits per tile code (0 empty, 1 soft block, 2 hard wall, 3 power-up).
REQ-004 Parameter N_CH, default 2, number of collision query channels (one per player sprite).
REQ-005 Parameters X_OFF, default 48, and Y_OFF, default 32: arena origin in screen pixels.
REQ-006 clk  in  1  sole clock; reset  in  1  synchronous, active-high.
REQ-007 display_on  in  1  active video; arena_on  in  1  pixel inside arena; x_a, y_a  in  10 each  arena-relative pixel coordinate.
REQ-008 q_valid  in  N_CH  channel query enable; q_x, q_y  in  10*N_CH each  sprite upper-left screen coordinate; q_dir  in  2*N_CH  direction (0 up, 1 right, 2 down, 3 left).
REQ-009 blocked  out  N_CH  per-channel blocked flag; q_done  out  1  scan-complete pulse.
REQ-010 wr_req  in  1; wr_col  in  6; wr_row  in  5; wr_data  in  TILE_W; wr_ack  out  1; wr_err  out  1.
REQ-011 tile_code  out  TILE_W  tile at current pixel; tile_on  out  1  pixel belongs to non-empty tile.
REQ-012 clear_req  in  1; busy  out  1 (see Configuration).

Function
REQ-013 Storage: COLS*ROWS entries of TILE_W bits, address = row*COLS + col; one write port, one shared read port.
REQ-014 Display read: when display_on & arena_on, read address uses col=x_a[9:4], row=y_a[9:4]; tile_code valid 1 cycle later; tile_on = registered (display_on & arena_on) & tile_code!=0.
REQ-015 Outside display_on & arena_on, tile_code=0 and tile_on=0 on the following cycle.
REQ-016 Scan FSM states IDLE, SCAN, DONE; IDLE->SCAN on display_on falling edge (display_on 1 in previous cycle, 0 now); q_valid sampled at SCAN entry.
REQ-017 SCAN visits channels 0..N_CH-1 in ascending order, one read per cycle; channels with sampled q_valid=0 take one cycle and hold blocked.
REQ-018 Probe point per direction: left (q_x-1, q_y+17), right (q_x+16, q_y+17), up (q_x+7, q_y+8), down (q_x+7, q_y+25), then minus X_OFF/Y_OFF; all 10-bit modulo arithmetic.
REQ-019 Probe col=px[9:4], row=py[9:4]; col>=COLS or row>=ROWS (incl. wrapped negatives) yields blocked=1 without memory access.
REQ-020 blocked[i] = 1 for codes 1 and 2, 0 for codes 0 and 3; updated 1 cycle after its read.
REQ-021 After last channel updates, DONE asserts q_done for exactly 1 cycle, then IDLE.
REQ-022 display_on rising during SCAN aborts to IDLE: already-updated channels keep new values, others hold, no q_done.
REQ-023 Write: wr_req with in-range col/row stores wr_data and pulses wr_ack the next cycle; out-of-range pulses wr_err instead, no store.
REQ-024 Write and read to same address in same cycle: read returns old data.
REQ-025 Writes accepted every cycle, including during SCAN and display.

Reset
REQ-026 Reset forces FSM IDLE, blocked=0, q_done=0, wr_ack=0, wr_err=0, tile_code=0, tile_on=0, busy=0.
REQ-027 Map contents not affected by reset.
REQ-028 Reset asserted mid-scan abandons scan; no q_done.

Configuration
REQ-029 Macro TILE_MAP_CLEAR_EN defined: clear_req pulse while not busy starts clear sequencer writing 0 to addresses 0..COLS*ROWS-1, one per cycle; busy high throughout; wr_req ignored (no wr_ack/wr_err) while busy; display/scan reads continue.
REQ-030 Macro undefined: clear_req ignored, busy constant 0, no sequencer logic.

Verification
REQ-031 Write (col 3,row 2,data 2); next cycle wr_ack=1; pixel x_a=56,y_a=40 with display_on=arena_on=1 -> tile_code=2, tile_on=1 one cycle later.
REQ-032 Write (col 40,row 0) -> wr_err=1, wr_ack=0, map unchanged.
REQ-033 Tile (1,1)=1; ch0 q_x=64,q_y=23,q_dir=2; display_on falls -> blocked[0]=1, q_done pulses 3 cycles after falling edge (N_CH=2).
REQ-034 Same as REQ-033 with tile code 3 -> blocked[0]=0; ch1 q_x=40,q_dir=3 (probe col wraps) -> blocked[1]=1.
REQ-035 display_on rises 1 cycle into SCAN -> blocked[1] unchanged, q_done never asserted.
REQ-036 With TILE_MAP_CLEAR_EN: clear_req -> busy high 858 cycles, then all tiles read 0; concurrent wr_req gets no wr_ack.
